// File: rtl/button_pkg.sv
// Shared definitions for the push-button debouncer and its synchroniser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package button_pkg;

  // Debounce FSM state encoding
  localparam logic [1:0] RELEASED     = 2'd0;
  localparam logic [1:0] PRESS_PEND   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_PEND = 2'd3;

  // Default flip-flop synchroniser depth
  localparam int DEFAULT_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for an asynchronous single-bit pin (STAGES legal range 2..4).
// Latency: STAGES clk cycles from d to q.
// Backpressure: none; samples every cycle.
module sync_ff
  import button_pkg::*;
#(
  parameter int STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  // Shift the raw pin through the chain; the first stage may go metastable
  always_ff @(posedge clk) begin
    if (!rst) sr <= '0;
    else      sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/button_debouncer.sv
// Synchronises and debounces a push-button; emits level plus press/release strobes.
// Latency: SYNC_STAGES + 2**WIDTH + 1 clk cycles from a stable input change to btn_level.
// Backpressure: none; strobes are single-cycle and must be consumed when seen.
// Optional: define PRESS_COUNT_EN to add the 8-bit wrapping press_count output.
module button_debouncer
  import button_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_press,
  output logic       btn_release
`ifdef PRESS_COUNT_EN
  ,
  output logic [7:0] press_count
`endif
);

  logic             btn_s;
  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt;
  logic             cnt_full;
  logic             level_nxt, press_nxt, release_nxt;

  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (btn_in),
    .q   (btn_s)
  );

  // The window only ever needs to be detected at its end, so no wrap handling
  assign cnt_full = &cnt;

  // State and stability counter registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RELEASED;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next state: any reversion while pending abandons the window and restarts it
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + {{(WIDTH-1){1'b0}}, 1'b1};
    case (state)
      RELEASED: begin
        cnt_nxt = '0;
        if (btn_s) state_nxt = PRESS_PEND;
      end
      PRESS_PEND: begin
        if (!btn_s) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end else if (cnt_full) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end
      end
      PRESSED: begin
        cnt_nxt = '0;
        if (!btn_s) state_nxt = RELEASE_PEND;
      end
      RELEASE_PEND: begin
        if (btn_s) begin
          state_nxt = PRESSED;
          cnt_nxt   = '0;
        end else if (cnt_full) begin
          state_nxt = RELEASED;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = RELEASED;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output decode: level and strobes change only when a pending window completes
  always_comb begin
    level_nxt   = btn_level;
    press_nxt   = 1'b0;
    release_nxt = 1'b0;
    if (state == PRESS_PEND && btn_s && cnt_full) begin
      level_nxt = 1'b1;
      press_nxt = 1'b1;
    end
    if (state == RELEASE_PEND && !btn_s && cnt_full) begin
      level_nxt   = 1'b0;
      release_nxt = 1'b1;
    end
  end

  // Register all outputs so nothing combinational reaches the pins
  always_ff @(posedge clk) begin
    if (!rst) begin
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
    end
  end

`ifdef PRESS_COUNT_EN
  // Count committed presses; wraps naturally at 8 bits
  always_ff @(posedge clk) begin
    if (!rst)           press_count <= '0;
    else if (btn_press) press_count <= press_count + 8'd1;
  end
`endif

endmodule
